// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots 64 systolic-array results and streams them out over valid/ready.
// Optional build macro SA_DRAIN_SAT8_EN: OUT_DATA = min(value >> SHIFT, 255), zero-extended.
module sa_result_drain #(
  parameter int SHIFT = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [1215:0] Y_FLAT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [18:0]   OUT_DATA,
  output logic [2:0]    OUT_ROW,
  output logic [2:0]    OUT_COL,
  output logic          OUT_LAST,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e      state_q;
  logic [5:0]  k_q;
  logic [5:0]  k_d;
  logic [18:0] mem_q [64];
  logic [18:0] data_q;
  logic [2:0]  row_q;
  logic [2:0]  col_q;
  logic        valid_q;
  logic        last_q;
  logic        busy_q;
  logic        done_q;

  // Output formatting: raw value, or shifted and clamped to 8 bits.
  function automatic logic [18:0] fmt(input logic [18:0] v);
`ifdef SA_DRAIN_SAT8_EN
    logic [18:0] s;
    s = v >> SHIFT;
    fmt = (s > 19'd255) ? 19'd255 : s;
`else
    fmt = v;
`endif
  endfunction

`ifndef SA_DRAIN_SAT8_EN
  logic unused_shift;
  assign unused_shift = ^SHIFT;
`endif

  // Index of the beat that follows the one currently presented.
  always_comb begin
    k_d = k_q + 6'd1;
  end

  // Snapshot buffer, loaded only on an accepted capture request.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && START) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= Y_FLAT[19*i +: 19];
      end
    end
  end

  // Drain FSM with registered beat outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            state_q <= STREAM;
            k_q     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            data_q  <= fmt(Y_FLAT[18:0]);
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
          end
        end
        STREAM: begin
          if (OUT_READY) begin
            if (k_q == 6'd63) begin
              state_q <= IDLE;
              k_q     <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              data_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              k_q    <= k_d;
              data_q <= fmt(mem_q[k_d]);
              row_q  <= k_d[5:3];
              col_q  <= k_d[2:0];
              last_q <= (k_d == 6'd63);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_ROW   = row_q;
  assign OUT_COL   = col_q;
  assign OUT_LAST  = last_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter SHIFT, default 8: right-shift applied before 8-bit saturation; used only when SA_DRAIN_SAT8_EN is defined.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 START  input  1  capture request; sampled only in IDLE.
REQ-005 Y_FLAT  input  1216  the 64 systolic-array results, 19 bits each; Y_ij occupies bits [19*k +: 19], where k = 8*i + j.
REQ-006 OUT_VALID  output  1  a result beat is presented.
REQ-007 OUT_READY  input  1  the consumer accepts the beat.
REQ-008 OUT_DATA  output  19  result value.
REQ-009 OUT_ROW  output  3  i of the current beat.
REQ-010 OUT_COL  output  3  j of the current beat.
REQ-011 OUT_LAST  output  1  high on beat k = 63 only.
REQ-012 BUSY  output  1  high while a drain is in progress.
REQ-013 DONE  output  1  one-cycle pulse when a drain completes.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and STREAM.
REQ-015 In IDLE with START=1 at a rising edge, the block SHALL snapshot all of Y_FLAT into a 64-entry internal buffer, set the beat index k=0, and enter STREAM.
REQ-016 From the edge after capture, OUT_VALID SHALL be 1 throughout STREAM, with OUT_DATA, OUT_ROW and OUT_COL driven from buffer entry k (OUT_ROW = k[5:3], OUT_COL = k[2:0]).
REQ-017 A beat is accepted on any edge where OUT_VALID=1 and OUT_READY=1; at that edge k SHALL increment by 1.
REQ-018 While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_ROW, OUT_COL and OUT_LAST SHALL hold stable; OUT_VALID SHALL NOT drop before acceptance.
REQ-019 On acceptance of beat 63, the block SHALL return to IDLE: OUT_VALID=0, BUSY=0 and DONE=1 in the following cycle, with DONE returning to 0 one cycle later.
REQ-020 BUSY SHALL equal 1 exactly while in STREAM.
REQ-021 START asserted during STREAM, including the cycle beat 63 is accepted, SHALL be ignored and SHALL NOT be queued.
REQ-022 Changes on Y_FLAT after capture SHALL NOT affect any streamed value.
REQ-023 With OUT_READY held at 1, a full drain SHALL take exactly 64 cycles of OUT_VALID, and DONE SHALL pulse 65 cycles after the capture edge.
REQ-024 Back-to-back drains SHALL be possible: START in the DONE cycle (state IDLE) SHALL be accepted.
REQ-025 Y_FLAT values are unsigned; no sign extension SHALL be performed.

Reset
REQ-026 While RST=0, the block SHALL force state IDLE, k=0, and OUT_VALID=0, OUT_DATA=0, OUT_ROW=0, OUT_COL=0, OUT_LAST=0, BUSY=0, DONE=0, regardless of CLK.
REQ-027 Reset asserted mid-drain SHALL abort the drain without a DONE pulse; buffer contents are don't-care.
REQ-028 After RST deasserts, the first START SHALL be honoured on the first rising edge.

Configuration
REQ-029 With macro SA_DRAIN_SAT8_EN defined, OUT_DATA SHALL equal min(buffer[k] >> SHIFT, 255), zero-extended to 19 bits.
REQ-030 Without SA_DRAIN_SAT8_EN, OUT_DATA SHALL equal buffer[k] unmodified, and SHIFT SHALL be unused.
REQ-031 The handshake, ordering and timing SHALL be identical in both builds.

Verification
REQ-032 Y_ij = 100*i + j, OUT_READY=1, START pulse -> 64 beats, beat 9 = (row 1, col 1, data 101), OUT_LAST only on beat 63 (data 707), DONE 65 cycles after capture.
REQ-033 OUT_READY toggling 1-0-1 on every edge -> beat order and values as above, data stable during stalls, exactly 64 acceptances.
REQ-034 Change Y_FLAT to all 0x7FFFF right after capture, and pulse START at k=30 -> streamed values are the original ones, and no second drain occurs.
REQ-035 RST=0 asserted asynchronously at k=20 -> all outputs 0 immediately, no DONE; a new START after release streams from k=0.
REQ-036 SA_DRAIN_SAT8_EN defined, SHIFT=8, Y_00=0x7FFFF, Y_01=0x01234 -> OUT_DATA 255, then 0x12; macro undefined -> 0x7FFFF, then 0x01234.
REQ-037 START in the DONE cycle -> second drain begins on the next cycle, with BUSY low for exactly one cycle.
